// File: rtl/npu_pkg.sv
// Shared geometry, tap count and sequencer state encoding for the NPU
// convolution sequencer slice.
package npu_pkg;
  localparam int unsigned WIDTH    = 80;
  localparam int unsigned HEIGHT   = 8;
  localparam int unsigned WIDTH_B  = 7;
  localparam int unsigned HEIGHT_B = 3;
  localparam int unsigned TAPS     = 9;

  typedef logic [WIDTH_B-1:0]  col_t;
  typedef logic [HEIGHT_B-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/npu_conv_sequencer_if.sv
// Host-facing configuration/control bundle and datapath control outputs
// of the convolution sequencer.
interface npu_conv_sequencer_if;
  import npu_pkg::*;

  logic                         start;
  logic                         abort;
  logic [WIDTH_B-1:0]           cfg_w;
  logic [HEIGHT_B:0]            cfg_h;
  logic [2:0]                   cfg_steps;
  logic [2:0]                   cfg_bound;
  logic                         cfg_relu;
  logic                         cfg_mp;
  logic [WIDTH_B*TAPS-1:0]      readi_w;
  logic [HEIGHT_B*TAPS-1:0]     readi_h;
  logic [TAPS-1:0]              en_read;
  logic                         en_bias;
  logic [2:0]                   step;
  logic                         en_pe;
  logic [2:0]                   step_p;
  logic [2:0]                   bound_level;
  logic                         en_relu;
  logic                         en_mp;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;

  modport master (
    output start, abort, cfg_w, cfg_h, cfg_steps, cfg_bound, cfg_relu, cfg_mp,
    input  readi_w, readi_h, en_read, en_bias, step, en_pe, step_p,
           bound_level, en_relu, en_mp, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_w, cfg_h, cfg_steps, cfg_bound, cfg_relu, cfg_mp,
    output readi_w, readi_h, en_read, en_bias, step, en_pe, step_p,
           bound_level, en_relu, en_mp, busy, done, cfg_err
  );
endinterface

// File: rtl/npu_win_addr.sv
// Combinational 3x3 window address generator: tap k=3r+c reads (x+c, y+r),
// tap 0 packed into the MSBs.
module npu_win_addr
  import npu_pkg::*;
(
  input  col_t                     x,
  input  row_t                     y,
  output logic [WIDTH_B*TAPS-1:0]  readi_w,
  output logic [HEIGHT_B*TAPS-1:0] readi_h
);
  always_comb begin
    readi_w = '0;
    readi_h = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        readi_w[(TAPS-1-(3*r+c))*WIDTH_B +: WIDTH_B]  = x + col_t'(c);
        readi_h[(TAPS-1-(3*r+c))*HEIGHT_B +: HEIGHT_B] = y + row_t'(r);
      end
    end
  end
endmodule

// File: rtl/npu_conv_sequencer.sv
// Convolution window sequencer: walks channel steps, columns and rows of
// every 3x3 window, then drains the PE pipeline and pulses done.
module npu_conv_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4
) (
  input logic                 clk,
  input logic                 reset,
  npu_conv_sequencer_if.slave bus
);
  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  state_e                   state_q;
  col_t                     x_q, x_d, w_last;
  row_t                     y_q, y_d;
  logic [2:0]               s_q, s_d, steps_q;
  logic [WIDTH_B-1:0]       w_q;
  logic [HEIGHT_B:0]        h_q, h_last;
  logic [DW-1:0]            drain_q;
  logic                     s_wrap, x_wrap, last_issue, cfg_ok;
  logic [WIDTH_B*TAPS-1:0]  addr_w, readi_w_q;
  logic [HEIGHT_B*TAPS-1:0] addr_h, readi_h_q;
  logic [TAPS-1:0]          en_read_q;
  logic [2:0]               step_q, step_p_q, bound_q;
  logic                     en_bias_q, en_pe_q, relu_q, mp_q, busy_q, done_q, cfg_err_q;

  // Addresses are computed for the issue about to be registered, so the
  // window origin is forced to (0,0) while waiting in IDLE.
  always_comb begin
    w_last     = w_q - col_t'(3);
    h_last     = h_q - 4'd3;
    s_wrap     = (s_q == steps_q);
    x_wrap     = (x_q == w_last);
    last_issue = s_wrap && x_wrap && ({1'b0, y_q} == h_last);
    s_d = '0;
    x_d = '0;
    y_d = '0;
    if (state_q == RUN) begin
      s_d = s_wrap ? 3'd0 : s_q + 3'd1;
      x_d = s_wrap ? (x_wrap ? col_t'(0) : x_q + col_t'(1)) : x_q;
      y_d = (s_wrap && x_wrap) ? y_q + row_t'(1) : y_q;
    end
    cfg_ok = (bus.cfg_w >= col_t'(3)) && (bus.cfg_w <= col_t'(WIDTH)) &&
             (bus.cfg_h >= 4'd3) && (bus.cfg_h <= 4'(HEIGHT));
  end

  npu_win_addr u_win_addr (
    .x       (x_d),
    .y       (y_d),
    .readi_w (addr_w),
    .readi_h (addr_h)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      steps_q   <= '0;
      drain_q   <= '0;
      readi_w_q <= '0;
      readi_h_q <= '0;
      en_read_q <= '0;
      en_bias_q <= 1'b0;
      step_q    <= '0;
      en_pe_q   <= 1'b0;
      step_p_q  <= '0;
      bound_q   <= '0;
      relu_q    <= 1'b0;
      mp_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (state_q != IDLE && bus.abort) begin
      state_q   <= IDLE;
      en_pe_q   <= 1'b0;
      en_read_q <= '0;
      en_bias_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          w_q       <= bus.cfg_w;
          h_q       <= bus.cfg_h;
          steps_q   <= bus.cfg_steps;
          bound_q   <= bus.cfg_bound;
          relu_q    <= bus.cfg_relu;
          mp_q      <= bus.cfg_mp;
          cfg_err_q <= !cfg_ok;
          x_q       <= '0;
          y_q       <= '0;
          s_q       <= '0;
          if (cfg_ok) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            en_pe_q   <= 1'b1;
            en_read_q <= '1;
            en_bias_q <= 1'b1;
            step_q    <= '0;
            step_p_q  <= '0;
            readi_w_q <= addr_w;
            readi_h_q <= addr_h;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        RUN: if (last_issue) begin
          state_q   <= DRAIN;
          drain_q   <= '0;
          en_pe_q   <= 1'b0;
          en_read_q <= '0;
          en_bias_q <= 1'b0;
        end else begin
          x_q       <= x_d;
          y_q       <= y_d;
          s_q       <= s_d;
          step_q    <= s_d;
          step_p_q  <= s_d;
          en_bias_q <= (s_d == 3'd0);
          readi_w_q <= addr_w;
          readi_h_q <= addr_h;
        end
        DRAIN: if (drain_q == DW'(PIPE_LAT - 1)) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          drain_q <= drain_q + DW'(1);
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.readi_w     = readi_w_q;
  assign bus.readi_h     = readi_h_q;
  assign bus.en_read     = en_read_q;
  assign bus.en_bias     = en_bias_q;
  assign bus.step        = step_q;
  assign bus.en_pe       = en_pe_q;
  assign bus.step_p      = step_p_q;
  assign bus.bound_level = bound_q;
  assign bus.en_relu     = relu_q;
  assign bus.en_mp       = mp_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
endmodule
